// File: rtl/quad_pkg.sv
// Shared constants, state encoding and snapshot type for the quad-rotor motor mixer.
package quad_pkg;

   localparam int MIN_RUN   = 704;
   localparam int CAL_SPEED = 432;
   localparam int SUM_W     = 14;
   localparam int SPD_W     = 11;

   // State encoding kept as plain constants so older code can compare raw codes.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_FRNT = 3'd1;
   localparam state_t ST_BCK  = 3'd2;
   localparam state_t ST_LFT  = 3'd3;
   localparam state_t ST_RGHT = 3'd4;

   typedef struct packed {
      logic        cal;
      logic [8:0]  thrst;
      logic [9:0]  ptch_p;
      logic [9:0]  roll_p;
      logic [9:0]  yaw_p;
      logic [11:0] ptch_d;
      logic [11:0] roll_d;
      logic [11:0] yaw_d;
   } terms_t;

   // Clamp a two's-complement sum into the unsigned motor speed range.
   function automatic logic [SPD_W-1:0] sat_spd(input logic [SUM_W-1:0] sum);
      if (sum[SUM_W-1])
         return '0;
      else if (|sum[SUM_W-2:SPD_W])
         return '1;
      else
         return sum[SPD_W-1:0];
   endfunction

endpackage

// File: rtl/flight_mix_if.sv
// Mixer bus: PD terms and thrust in, four registered motor speeds and a valid pulse out.
interface flight_mix_if;
   import quad_pkg::*;

   logic             vld;
   logic             inertial_cal;
   logic [8:0]       thrst;
   logic [9:0]       ptch_pterm;
   logic [9:0]       roll_pterm;
   logic [9:0]       yaw_pterm;
   logic [11:0]      ptch_dterm;
   logic [11:0]      roll_dterm;
   logic [11:0]      yaw_dterm;
   logic [SPD_W-1:0] frnt_spd;
   logic [SPD_W-1:0] bck_spd;
   logic [SPD_W-1:0] lft_spd;
   logic [SPD_W-1:0] rght_spd;
   logic             spd_vld;

   modport master (
      output vld, inertial_cal, thrst,
      output ptch_pterm, roll_pterm, yaw_pterm,
      output ptch_dterm, roll_dterm, yaw_dterm,
      input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
   );

   modport slave (
      input  vld, inertial_cal, thrst,
      input  ptch_pterm, roll_pterm, yaw_pterm,
      input  ptch_dterm, roll_dterm, yaw_dterm,
      output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
   );

endinterface

// File: rtl/motor_sum_sat.sv
// Shared mixer datapath: picks the sign pattern for the motor named by sel, sums, saturates.
module motor_sum_sat
   import quad_pkg::*;
(
   input  state_t           sel,
   input  terms_t           terms,
   output logic [SPD_W-1:0] spd
);

   logic [SUM_W-1:0] base;
   logic [SUM_W-1:0] ptch_t;
   logic [SUM_W-1:0] roll_t;
   logic [SUM_W-1:0] yaw_t;
   logic [SUM_W-1:0] sum;

   always_comb begin
      base   = SUM_W'(MIN_RUN) + {{(SUM_W-9){1'b0}}, terms.thrst};
      ptch_t = {{(SUM_W-10){terms.ptch_p[9]}}, terms.ptch_p}
             + {{(SUM_W-12){terms.ptch_d[11]}}, terms.ptch_d};
      roll_t = {{(SUM_W-10){terms.roll_p[9]}}, terms.roll_p}
             + {{(SUM_W-12){terms.roll_d[11]}}, terms.roll_d};
      yaw_t  = {{(SUM_W-10){terms.yaw_p[9]}}, terms.yaw_p}
             + {{(SUM_W-12){terms.yaw_d[11]}}, terms.yaw_d};

      case (sel)
         ST_FRNT: sum = base + ptch_t - yaw_t;
         ST_BCK:  sum = base - ptch_t - yaw_t;
         ST_LFT:  sum = base - roll_t + yaw_t;
         ST_RGHT: sum = base + roll_t + yaw_t;
         default: sum = '0;
      endcase

      spd = terms.cal ? SPD_W'(CAL_SPEED) : sat_spd(sum);
   end

endmodule

// File: rtl/flight_mix.sv
// Quad-rotor motor mixer: snapshots PD terms, computes one motor per cycle through a shared
// datapath, then publishes all four speeds together with a one-cycle valid pulse.
module flight_mix
   import quad_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   flight_mix_if.slave bus
);

   terms_t           in_terms;
   logic [SPD_W-1:0] mix_spd;

   state_t           state_q,     state_d;
   terms_t           work_q,      work_d;
   terms_t           pend_q,      pend_d;
   logic             pend_vld_q,  pend_vld_d;
   logic [SPD_W-1:0] shd_frnt_q,  shd_frnt_d;
   logic [SPD_W-1:0] shd_bck_q,   shd_bck_d;
   logic [SPD_W-1:0] shd_lft_q,   shd_lft_d;
   logic [SPD_W-1:0] frnt_spd_q,  frnt_spd_d;
   logic [SPD_W-1:0] bck_spd_q,   bck_spd_d;
   logic [SPD_W-1:0] lft_spd_q,   lft_spd_d;
   logic [SPD_W-1:0] rght_spd_q,  rght_spd_d;
   logic             spd_vld_q,   spd_vld_d;

   assign in_terms = '{
      cal:    bus.inertial_cal,
      thrst:  bus.thrst,
      ptch_p: bus.ptch_pterm,
      roll_p: bus.roll_pterm,
      yaw_p:  bus.yaw_pterm,
      ptch_d: bus.ptch_dterm,
      roll_d: bus.roll_dterm,
      yaw_d:  bus.yaw_dterm
   };

   motor_sum_sat u_sum_sat (
      .sel   (state_q),
      .terms (work_q),
      .spd   (mix_spd)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      work_d     = work_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      shd_frnt_d = shd_frnt_q;
      shd_bck_d  = shd_bck_q;
      shd_lft_d  = shd_lft_q;
      frnt_spd_d = frnt_spd_q;
      bck_spd_d  = bck_spd_q;
      lft_spd_d  = lft_spd_q;
      rght_spd_d = rght_spd_q;
      spd_vld_d  = 1'b0;

      if (bus.vld && (state_q != ST_IDLE)) begin
         pend_d     = in_terms;
         pend_vld_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.vld) begin
               work_d  = in_terms;
               state_d = ST_FRNT;
            end
         end
         ST_FRNT: begin
            shd_frnt_d = mix_spd;
            state_d    = ST_BCK;
         end
         ST_BCK: begin
            shd_bck_d = mix_spd;
            state_d   = ST_LFT;
         end
         ST_LFT: begin
            shd_lft_d = mix_spd;
            state_d   = ST_RGHT;
         end
         ST_RGHT: begin
            frnt_spd_d = shd_frnt_q;
            bck_spd_d  = shd_bck_q;
            lft_spd_d  = shd_lft_q;
            rght_spd_d = mix_spd;
            spd_vld_d  = 1'b1;
            // A vld arriving on this very edge is the newest request and goes straight in.
            if (pend_vld_d) begin
               work_d     = pend_d;
               pend_vld_d = 1'b0;
               state_d    = ST_FRNT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: these are plain registers, not RAM, so clearing them all on reset is cheap and makes aborts clean.
         state_q    <= ST_IDLE;
         work_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         shd_frnt_q <= '0;
         shd_bck_q  <= '0;
         shd_lft_q  <= '0;
         frnt_spd_q <= '0;
         bck_spd_q  <= '0;
         lft_spd_q  <= '0;
         rght_spd_q <= '0;
         spd_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         shd_frnt_q <= shd_frnt_d;
         shd_bck_q  <= shd_bck_d;
         shd_lft_q  <= shd_lft_d;
         frnt_spd_q <= frnt_spd_d;
         bck_spd_q  <= bck_spd_d;
         lft_spd_q  <= lft_spd_d;
         rght_spd_q <= rght_spd_d;
         spd_vld_q  <= spd_vld_d;
      end
   end

   assign bus.frnt_spd = frnt_spd_q;
   assign bus.bck_spd  = bck_spd_q;
   assign bus.lft_spd  = lft_spd_q;
   assign bus.rght_spd = rght_spd_q;
   assign bus.spd_vld  = spd_vld_q;

endmodule

// File: doc/flight_mix.md
FLIGHT_MIX -- requirements
Module: flight_mix

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port vld, input, 1 bit: a new set of PD terms is valid this cycle.
REQ-004 SHALL have port inertial_cal, input, 1 bit: calibration mode request.
REQ-005 SHALL have port thrst, input, 9 bits unsigned: thrust.
REQ-006 SHALL have ports ptch_pterm, roll_pterm, yaw_pterm, input, 10 bits signed each.
REQ-007 SHALL have ports ptch_dterm, roll_dterm, yaw_dterm, input, 12 bits signed each.
REQ-008 SHALL have ports frnt_spd, bck_spd, lft_spd, rght_spd, output, 11 bits unsigned each: registered motor speeds.
REQ-009 SHALL have port spd_vld, output, 1 bit: registered one-cycle pulse when a new speed set is presented.

Function
REQ-010 SHALL snapshot all inputs into the working register set on a clk edge where vld=1 and state=IDLE, then move to FRNT.
REQ-011 SHALL sequence the states IDLE -> FRNT -> BCK -> LFT -> RGHT, one cycle each, using one shared summing/saturation datapath.
REQ-012 SHALL use these sums, each computed as 14-bit signed with MIN_RUN=704 and thrst zero-extended:
- frnt = MIN_RUN + thrst + ptch_p + ptch_d - yaw_p - yaw_d
- bck = MIN_RUN + thrst - ptch_p - ptch_d - yaw_p - yaw_d
- lft = MIN_RUN + thrst - roll_p - roll_d + yaw_p + yaw_d
- rght = MIN_RUN + thrst + roll_p + roll_d + yaw_p + yaw_d
REQ-013 SHALL saturate each sum: negative -> 0; >2047 -> 2047; otherwise the low 11 bits.
REQ-014 SHALL write the FRNT, BCK and LFT results into shadow registers.
REQ-015 SHALL, on the RGHT-exit edge, update all four outputs simultaneously, so a mixed old/new set is never visible.
REQ-016 SHALL assert spd_vld for exactly the one cycle following the RGHT-exit edge.
- Latency: snapshot edge at t0 gives outputs updated and spd_vld high after edge t4.
REQ-017 SHALL, when the snapshotted inertial_cal=1, produce CAL_SPEED=432 on all four motors and ignore all terms.
REQ-018 SHALL, on vld=1 while state is not IDLE (including RGHT), capture inputs into a one-deep pending snapshot and set the pending flag; a later vld overwrites it (latest wins).
REQ-019 SHALL, on leaving RGHT with pending=1, copy the pending snapshot to the working set, clear pending, and go to FRNT; otherwise go to IDLE.
REQ-020 SHALL hold the outputs between updates; spd_vld=0 except per REQ-016.

Reset
REQ-021 SHALL, while rst_n=0, force:
- state to IDLE and pending to 0;
- all working, pending and shadow registers to 0;
- all four speed outputs to 0 and spd_vld to 0.
REQ-022 SHALL, on reset asserted mid-sequence, abort the sequence with no spd_vld pulse and no output update.
REQ-023 SHALL accept vld from the first clk edge after rst_n deasserts.

Structure
REQ-024 SHALL place MIN_RUN (704), CAL_SPEED (432), the 14-bit sum width, the 11-bit speed width and the state enum in shared package quad_pkg.
REQ-025 SHALL implement the shared adder and saturator as one combinational sub-module, motor_sum_sat, selected by the current state.

Verification
REQ-026 SHALL drive thrst=0, all terms 0, cal=0, one vld -> all speeds 704, spd_vld pulse after edge t4, outputs 0 before.
REQ-027 SHALL drive thrst=256, ptch_p=100, ptch_d=50, others 0 -> frnt=1110, bck=810, lft=960, rght=960.
REQ-028 SHALL cover saturation in two runs:
- thrst=511, ptch_p=511, ptch_d=2047, yaw_p=-512, yaw_d=-2048 -> frnt=2047, bck=1217.
- thrst=0, roll_p=-512, roll_d=-2048 -> rght=0.
REQ-029 SHALL drive inertial_cal=1 with arbitrary nonzero terms -> all speeds 432.
REQ-030 SHALL pulse vld at t0, t1 and t2 with distinct term sets A, B, C -> set A output at t4, set C output at t8, set B never output, exactly two spd_vld pulses.
REQ-031 SHALL assert rst_n=0 in state LFT after a completed prior set -> all outputs 0, no spd_vld; a fresh vld after release completes normally.
